mem_stage: RTL and testbench

//  MEM pipeline stage: consumes the EX/MEM register outputs and performs the data-memory access.

---
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage.sv | 88 ++++++++
 tb/tb_mem_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bus between the EX/MEM register and the MEM stage: EX/MEM fields in, load data and hazard controls out.
interface mem_stage_if;
  logic [2:0]  mem_ctrl_i;
  logic        zero_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        stall_o;
  logic        pc_src_o;
  logic        error_o;

  modport master (
    output mem_ctrl_i, zero_i, addr_i, wdata_i,
    input  rdata_o, rdata_valid_o, stall_o, pc_src_o, error_o
  );

  modport slave (
    input  mem_ctrl_i, zero_i, addr_i, wdata_i,
    output rdata_o, rdata_valid_o, stall_o, pc_src_o, error_o
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data RAM access with upstream stall, branch resolve and load return.
module mem_stage #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input logic        clk_i,
  input logic        rst_i,
  mem_stage_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_load_q;
  logic [31:0]      rdata_q;
  logic [31:0]      ram [DEPTH];

  logic          branch, mem_rd, mem_wr;
  logic          any_op, misaligned, out_of_range, error, req;
  logic          last_beat, stall;
  logic [AW-1:0] widx;

  assign {branch, mem_rd, mem_wr} = bus.mem_ctrl_i;
  assign any_op       = mem_rd | mem_wr;
  assign misaligned   = (bus.addr_i[1:0] != 2'b00);
  assign out_of_range = (bus.addr_i[31:2] >= 30'(DEPTH));
  assign error        = any_op & (misaligned | out_of_range);
  assign req          = any_op & ~error;
  assign widx         = bus.addr_i[2+AW-1:2];
  assign last_beat    = (state_q == ACCESS) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          stall   = 1'b1;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      // DONE never looks at the request: upstream is about to advance.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Op type is latched at launch; both read and write set counts as a store.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      is_load_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        cnt_q     <= '0;
        is_load_q <= mem_rd & ~mem_wr;
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (last_beat && is_load_q) rdata_q <= ram[widx];
    end
  end

  // Store commits only on the final access beat, so a reset before then drops it.
  always_ff @(posedge clk_i) begin
    if (rst_i && last_beat && !is_load_q) ram[widx] <= bus.wdata_i;
  end

  assign bus.rdata_o       = rdata_q;
  assign bus.rdata_valid_o = (state_q == DONE) && is_load_q;
  assign bus.stall_o       = stall;
  assign bus.pc_src_o      = branch & bus.zero_i;
  assign bus.error_o       = error;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (DEPTH=128, LATENCY=2).
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst_i;
  int   errors = 0;
  int   checks = 0;

  mem_stage_if bus ();

  mem_stage #(.DEPTH(128), .LATENCY(2)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata);
    bus.mem_ctrl_i = ctrl;
    bus.addr_i     = addr;
    bus.wdata_i    = wdata;
  endtask

  task automatic drive_idle();
    drive(3'b000, 32'h0, 32'h0);
    bus.zero_i = 1'b0;
  endtask

  // Called just after a negedge in the cycle where the request is first seen by IDLE.
  // Returns in the DONE cycle (stall low) with the outputs sampled there.
  task automatic run_access(output int n_stall, output logic valid_during_stall,
                            output logic valid_done, output logic [31:0] rd_done);
    n_stall            = 0;
    valid_during_stall = 1'b0;
    #1;
    while (bus.stall_o === 1'b1 && n_stall < 10) begin
      n_stall++;
      if (bus.rdata_valid_o !== 1'b0) valid_during_stall = 1'b1;
      @(negedge clk); #1;
    end
    if (n_stall >= 10) begin
      checks++; errors++;
      $display("FAIL access_timeout: stall still %b after %0d cycles, required low", bus.stall_o, n_stall);
    end
    valid_done = bus.rdata_valid_o;
    rd_done    = bus.rdata_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", bus.rdata_o, 32'h0); end
    checks++; if (bus.rdata_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.rdata_valid_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", bus.error_o); end
    rst_i = 1'b1;
  endtask

  task automatic test_store_load();
    int n; logic vs, vd; logic [31:0] rd;
    @(negedge clk);
    drive(3'b001, 32'h10, 32'hDEADBEEF);
    run_access(n, vs, vd, rd);
    checks++; if (n !== 3) begin errors++; $display("FAIL store_stall_cycles: got %0d want 3", n); end
    checks++; if (vd !== 1'b0) begin errors++; $display("FAIL store_valid: got %b want 0", vd); end
    drive_idle();
    @(negedge clk);
    drive(3'b010, 32'h10, 32'h0);
    run_access(n, vs, vd, rd);
    checks++; if (n !== 3) begin errors++; $display("FAIL load_stall_cycles: got %0d want 3", n); end
    checks++; if (vs !== 1'b0) begin errors++; $display("FAIL load_valid_early: got %b want 0", vs); end
    checks++; if (vd !== 1'b1) begin errors++; $display("FAIL load_valid_done: got %b want 1", vd); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want %h", rd, 32'hDEADBEEF); end
    drive_idle();
    @(negedge clk); #1;
    checks++; if (bus.rdata_valid_o !== 1'b0) begin errors++; $display("FAIL load_valid_after: got %b want 0", bus.rdata_valid_o); end
    checks++; if (bus.rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata_hold: got %h want %h", bus.rdata_o, 32'hDEADBEEF); end
  endtask

  task automatic test_error();
    logic [31:0] bad [2];
    bad[0] = 32'h12;
    bad[1] = 32'h200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(3'b010, bad[i], 32'h0);
      #1;
      checks++; if (bus.error_o !== 1'b1) begin errors++; $display("FAIL err_flag[%0d]: got %b want 1", i, bus.error_o); end
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL err_stall[%0d]: got %b want 0", i, bus.stall_o); end
      @(negedge clk); #1;
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL err_still_idle[%0d]: stall %b want 0", i, bus.stall_o); end
      checks++; if (bus.rdata_o !== 32'hDEADBEEF || bus.rdata_valid_o !== 1'b0) begin
        errors++; $display("FAIL err_rdata[%0d]: got %h/%b want %h/0", i, bus.rdata_o, bus.rdata_valid_o, 32'hDEADBEEF);
      end
    end
    drive_idle();
  endtask

  task automatic test_branch();
    @(negedge clk);
    drive(3'b100, 32'h0, 32'h0);
    bus.zero_i = 1'b1;
    #1;
    checks++; if (bus.pc_src_o !== 1'b1) begin errors++; $display("FAIL branch_taken: got %b want 1", bus.pc_src_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL branch_stall_taken: got %b want 0", bus.stall_o); end
    @(negedge clk);
    bus.zero_i = 1'b0;
    #1;
    checks++; if (bus.pc_src_o !== 1'b0) begin errors++; $display("FAIL branch_not_taken: got %b want 0", bus.pc_src_o); end
    @(negedge clk); #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL branch_stall_after: got %b want 0", bus.stall_o); end
    drive_idle();
  endtask

  task automatic test_reset_abort();
    int n; logic vs, vd; logic [31:0] rd;
    @(negedge clk);
    drive(3'b001, 32'h20, 32'h1111);
    run_access(n, vs, vd, rd);
    drive_idle();
    @(negedge clk);
    drive(3'b001, 32'h20, 32'h2222);
    #1;
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL abort_launch_stall: got %b want 1", bus.stall_o); end
    @(negedge clk);
    rst_i = 1'b0;
    drive_idle();
    @(negedge clk); #1;
    checks++; if (bus.stall_o !== 1'b0 || bus.rdata_o !== 32'h0) begin
      errors++; $display("FAIL abort_reset_state: stall %b rdata %h want 0/00000000", bus.stall_o, bus.rdata_o);
    end
    rst_i = 1'b1;
    @(negedge clk);
    drive(3'b010, 32'h20, 32'h0);
    run_access(n, vs, vd, rd);
    checks++; if (rd !== 32'h1111 || vd !== 1'b1) begin errors++; $display("FAIL abort_store_dropped: got %h/%b want %h/1", rd, vd, 32'h1111); end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    int n; logic vs, vd; logic [31:0] rd;
    @(negedge clk);
    drive(3'b010, 32'h10, 32'h0);
    run_access(n, vs, vd, rd);
    checks++; if (n !== 3 || vd !== 1'b1 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL b2b_load: stall %0d valid %b rdata %h want 3/1/%h", n, vd, rd, 32'hDEADBEEF);
    end
    drive(3'b001, 32'h14, 32'h5555AAAA);
    @(negedge clk);
    run_access(n, vs, vd, rd);
    checks++; if (n !== 3 || vd !== 1'b0) begin errors++; $display("FAIL b2b_store: stall %0d valid %b want 3/0", n, vd); end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL b2b_no_retrigger[%0d]: stall %b want 0", i, bus.stall_o); end
    end
    @(negedge clk);
    drive(3'b010, 32'h14, 32'h0);
    run_access(n, vs, vd, rd);
    checks++; if (rd !== 32'h5555AAAA) begin errors++; $display("FAIL b2b_readback: got %h want %h", rd, 32'h5555AAAA); end
    drive_idle();
  endtask

  task automatic test_read_write_both();
    int n; logic vs, vd; logic [31:0] rd;
    @(negedge clk);
    drive(3'b011, 32'h18, 32'h00000077);
    run_access(n, vs, vd, rd);
    checks++; if (n !== 3 || vd !== 1'b0 || rd !== 32'h5555AAAA) begin
      errors++; $display("FAIL rw_as_store: stall %0d valid %b rdata %h want 3/0/%h", n, vd, rd, 32'h5555AAAA);
    end
    drive_idle();
    @(negedge clk);
    drive(3'b010, 32'h18, 32'h0);
    run_access(n, vs, vd, rd);
    checks++; if (rd !== 32'h00000077) begin errors++; $display("FAIL rw_readback: got %h want %h", rd, 32'h00000077); end
    drive_idle();
  endtask

  initial begin
    rst_i = 1'b0;
    drive_idle();
    test_reset();
    test_store_load();
    test_error();
    test_branch();
    test_reset_abort();
    test_back_to_back();
    test_read_write_both();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
